// File: rtl/inst_fetch_pkg.sv
// Shared instruction fetch types: instruction word and IMEM address-width helper macro.
`ifndef INST_FETCH_IMEM_AW
`define INST_FETCH_IMEM_AW(depth) (((depth) > 1) ? $clog2(depth) : 1)
`endif

package inst_fetch_pkg;
  localparam int INST_W = 32;
  typedef logic [INST_W-1:0] instruction_t;
endpackage

// File: rtl/inst_fifo2.sv
// Two-entry instruction prefetch buffer with synchronous flush.
module inst_fifo2
  import inst_fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  instruction_t din,
  output instruction_t dout,
  output logic         full,
  output logic         empty,
  output logic [1:0]   count
);
  instruction_t mem [2];
  logic         wr_ptr, rd_ptr;
  logic [1:0]   cnt_q;
  logic         do_push, do_pop;

  assign do_pop  = pop && (cnt_q != 2'd0);
  // A pop frees the slot a same-cycle push may land in.
  assign do_push = push && ((cnt_q != 2'd2) || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt_q  <= 2'd0;
      mem[0] <= '0;
      mem[1] <= '0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt_q  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) rd_ptr <= ~rd_ptr;
      cnt_q <= cnt_q + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  assign dout  = mem[rd_ptr];
  assign full  = (cnt_q == 2'd2);
  assign empty = (cnt_q == 2'd0);
  assign count = cnt_q;
endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: prefetches program words from IMEM and issues them one at a
// time to the controller, waiting for inst_exec_begins between issues.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter  int IMEM_DEPTH = 256,
  localparam int AW = `INST_FETCH_IMEM_AW(IMEM_DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW:0]   prog_len,
  input  logic          halt,
  output logic          busy,
  output logic          done,
  output logic          imem_ren,
  output logic [AW-1:0] imem_addr,
  input  instruction_t  imem_rdata,
  output instruction_t  inst,
  output logic          inst_valid,
  input  logic          inst_exec_begins
);
  typedef enum logic [1:0] {IDLE, RUN, WAIT_EXEC, FINISH} state_t;

  state_t       state, state_nxt;
  logic [AW:0]  len_q, fetch_addr, issued, len_sat;
  logic         halt_q, halt_nxt;
  logic         rd_vld_p1;
  logic         ren_nxt, done_nxt;
  logic         fifo_push, fifo_pop, fifo_flush, fifo_full, fifo_empty;
  logic [1:0]   fifo_count;
  logic [2:0]   credits;
  instruction_t fifo_dout;

  function automatic logic [AW:0] sat_len(input logic [AW:0] len);
    return (len > (AW+1)'(IMEM_DEPTH)) ? (AW+1)'(IMEM_DEPTH) : len;
  endfunction

  assign len_sat = sat_len(prog_len);
  // Occupancy plus both read stages still on their way into the buffer.
  assign credits = {1'b0, fifo_count} + {2'b0, imem_ren} + {2'b0, rd_vld_p1};
  assign fifo_push = rd_vld_p1 && (state == RUN || state == WAIT_EXEC) && !halt && !halt_q
                     && (!fifo_full || fifo_pop);

  always_comb begin
    state_nxt  = state;
    halt_nxt   = halt_q;
    done_nxt   = 1'b0;
    fifo_pop   = 1'b0;
    fifo_flush = 1'b0;
    ren_nxt    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (len_sat != '0) state_nxt = RUN;
          else               done_nxt  = 1'b1;
        end
      end
      RUN: begin
        if (halt) begin
          state_nxt = FINISH;
        end else if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          state_nxt = WAIT_EXEC;
        end
      end
      WAIT_EXEC: begin
        if (halt) halt_nxt = 1'b1;
        if (inst_exec_begins)
          state_nxt = (halt || halt_q || issued == len_q) ? FINISH : RUN;
      end
      FINISH: begin
        fifo_flush = 1'b1;
        halt_nxt   = 1'b0;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (state != FINISH && state_nxt == FINISH) done_nxt = 1'b1;
    if (state == IDLE)
      ren_nxt = start && (len_sat != '0);
    else
      ren_nxt = (state_nxt == RUN || state_nxt == WAIT_EXEC) && !halt_nxt
                && (fetch_addr < len_q) && (credits < 3'd2);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      len_q      <= '0;
      fetch_addr <= '0;
      issued     <= '0;
      halt_q     <= 1'b0;
      rd_vld_p1  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      imem_ren   <= 1'b0;
      imem_addr  <= '0;
      inst_valid <= 1'b0;
      inst       <= '0;
    end else begin
      state      <= state_nxt;
      halt_q     <= halt_nxt;
      rd_vld_p1  <= imem_ren;
      busy       <= (state_nxt != IDLE);
      done       <= done_nxt;
      imem_ren   <= ren_nxt;
      inst_valid <= fifo_pop;
      if (state == IDLE && start) begin
        len_q  <= len_sat;
        issued <= '0;
        if (ren_nxt) begin
          imem_addr  <= '0;
          fetch_addr <= (AW+1)'(1);
        end else begin
          fetch_addr <= '0;
        end
      end else if (ren_nxt) begin
        imem_addr  <= fetch_addr[AW-1:0];
        fetch_addr <= fetch_addr + 1'b1;
      end
      if (fifo_pop) begin
        inst   <= fifo_dout;
        issued <= issued + 1'b1;
      end
    end
  end

  inst_fifo2 u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (fifo_flush),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (imem_rdata),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );
endmodule

// File: tb/tb_inst_fetch.sv
// Randomized self-checking bench for inst_fetch: IMEM and controller models plus
// an issue-order scoreboard derived from program length, halt point and latency rules.
module tb_inst_fetch;
  import inst_fetch_pkg::*;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          halt = 1'b0;
  logic          inst_exec_begins = 1'b0;
  logic [AW:0]   prog_len = '0;
  logic          busy, done, imem_ren, inst_valid;
  logic [AW-1:0] imem_addr;
  instruction_t  imem_rdata = '0;
  instruction_t  inst;

  int           n_vec = 0;
  int           n_err = 0;
  instruction_t mem [DEPTH];
  instruction_t exp_inst = '0;
  logic         ovf_seen = 1'b0;

  always #5 clk = ~clk;

  inst_fetch #(.IMEM_DEPTH(DEPTH)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start            (start),
    .prog_len         (prog_len),
    .halt             (halt),
    .busy             (busy),
    .done             (done),
    .imem_ren         (imem_ren),
    .imem_addr        (imem_addr),
    .imem_rdata       (imem_rdata),
    .inst             (inst),
    .inst_valid       (inst_valid),
    .inst_exec_begins (inst_exec_begins)
  );

  always @(negedge clk)
    if (rst_n)
      ovf_chk: assert (!(dut.u_fifo.push && dut.u_fifo.full && !dut.u_fifo.pop))
        else ovf_seen = 1'b1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // hmode: 0 none, 1 halt on k-th issue, 2 halt with k-th exec, 3 halt in RUN after k-th exec
  task automatic run_prog(input int len, input int dmin, input int dmax,
                          input int hmode, input int hk, input int restart_cyc);
    int n_eff, exp_issue, exp_done, t, max_cyc;
    int nvld, nren, ndone, done_cyc, first_vld, first_ren, last_exec, halt_cyc, exec_due;
    int addr_bad, b2b, hold_bad, late_ren;
    logic prev_ren, prev_vld;
    logic [AW-1:0] prev_addr;
    instruction_t got [$];

    for (int i = 0; i < DEPTH; i++) mem[i] = instruction_t'($urandom);
    n_eff     = (len > DEPTH) ? DEPTH : len;
    exp_issue = (hmode != 0) ? hk : n_eff;
    nvld = 0; nren = 0; ndone = 0; done_cyc = -1; first_vld = -1; first_ren = -1;
    last_exec = -1; halt_cyc = -1; exec_due = -1;
    addr_bad = 0; b2b = 0; hold_bad = 0; late_ren = 0;
    prev_ren = 1'b0; prev_vld = 1'b0; prev_addr = '0;
    max_cyc = 40 + 12 * n_eff;

    @(posedge clk); #1;
    start    = 1'b1;
    prog_len = len[AW:0];
    t = 0;
    while (t < max_cyc && (done_cyc < 0 || t < done_cyc + 2)) begin
      @(posedge clk); #1;
      t++;
      imem_rdata       = prev_ren ? mem[prev_addr] : instruction_t'($urandom);
      start            = (t == restart_cyc);
      if (t == restart_cyc) prog_len = (AW+1)'(1);
      halt             = 1'b0;
      inst_exec_begins = 1'b0;

      if (imem_ren) begin
        if (first_ren < 0) first_ren = t;
        if (int'(imem_addr) != nren || nren >= n_eff) addr_bad++;
        if (halt_cyc >= 0) late_ren++;
        nren++;
      end
      prev_ren  = imem_ren;
      prev_addr = imem_addr;

      if (inst_valid) begin
        if (prev_vld) b2b++;
        if (first_vld < 0) first_vld = t;
        got.push_back(inst);
        exp_inst = (nvld < DEPTH) ? mem[nvld] : '0;
        nvld++;
        exec_due = t + $urandom_range(dmax, dmin);
        if (hmode == 1 && nvld == hk) begin halt = 1'b1; halt_cyc = t; end
      end else if (inst !== exp_inst) begin
        hold_bad++;
      end
      prev_vld = inst_valid;

      if (t == exec_due) begin
        inst_exec_begins = 1'b1;
        last_exec = t;
        if (hmode == 2 && nvld == hk) begin halt = 1'b1; halt_cyc = t; end
      end
      if (hmode == 3 && nvld == hk && last_exec == t - 1 && halt_cyc < 0) begin
        halt = 1'b1;
        halt_cyc = t;
      end

      if (done) begin ndone++; done_cyc = t; end
      if (t == 1) chk("busy_after_start", busy, (len != 0));
      if (done_cyc >= 0 && t == done_cyc + 1) chk("busy_low_after_done", busy, 1'b0);
    end
    start = 1'b0; halt = 1'b0; inst_exec_begins = 1'b0;

    if (len == 0)        exp_done = 1;
    else if (hmode == 3) exp_done = halt_cyc + 1;
    else                 exp_done = last_exec + 1;

    chk("timeout", (done_cyc < 0), 1'b0);
    chk("done_count", ndone, 1);
    chk("done_cycle", done_cyc, exp_done);
    chk("issue_count", nvld, exp_issue);
    for (int i = 0; i < got.size() && i < exp_issue; i++)
      chk($sformatf("word%0d", i), got[i], mem[i]);
    chk("valid_b2b", b2b, 0);
    chk("inst_hold", hold_bad, 0);
    chk("addr_order", addr_bad, 0);
    if (hmode != 0) chk("reads_after_halt", late_ren, 0);
    else            chk("read_count", nren, n_eff);
    if (len != 0) begin
      chk("first_ren_cycle", first_ren, 1);
      chk("first_valid_cycle", first_vld, 4);
    end
    chk("fifo_overflow", ovf_seen, 1'b0);
  endtask

  task automatic reset_mid_program();
    int t;
    bit hit;
    logic prev_ren;
    logic [AW-1:0] prev_addr;
    int ndone;
    for (int i = 0; i < DEPTH; i++) mem[i] = instruction_t'($urandom);
    prev_ren = 1'b0; prev_addr = '0; ndone = 0; hit = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; prog_len = (AW+1)'(3);
    t = 0;
    while (t < 30 && !hit) begin
      @(posedge clk); #1;
      t++;
      start = 1'b0;
      imem_rdata = prev_ren ? mem[prev_addr] : instruction_t'($urandom);
      prev_ren = imem_ren; prev_addr = imem_addr;
      if (done) ndone++;
      if (inst_valid) begin
        hit = 1'b1;
        #2 rst_n = 1'b0;
        #1 chk("async_reset_outputs", {busy, done, imem_ren, inst_valid, imem_addr, inst}, '0);
      end
    end
    chk("reset_reached_wait", hit, 1'b1);
    chk("no_done_before_reset", ndone, 0);
    exp_inst = '0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("done_during_reset", done, 1'b0);
    rst_n = 1'b1;
  endtask

  initial begin
    int len, hm, hk, ne;
    repeat (3) @(posedge clk);
    #1 chk("reset_state", {busy, done, imem_ren, inst_valid, imem_addr, inst}, '0);
    rst_n = 1'b1;

    run_prog(3, 2, 2, 0, 0, -1);
    run_prog(0, 2, 2, 0, 0, -1);
    run_prog(4, 2, 2, 1, 2, -1);
    run_prog(5, 2, 2, 0, 0, 2);
    run_prog(6, 1, 1, 0, 0, -1);
    run_prog(20, 1, 3, 0, 0, -1);
    run_prog(5, 1, 2, 2, 3, -1);
    run_prog(5, 2, 2, 3, 2, -1);
    reset_mid_program();
    run_prog(1, 2, 2, 0, 0, -1);

    for (int r = 0; r < 10; r++) begin
      len = $urandom_range(DEPTH + 8, 1);
      ne  = (len > DEPTH) ? DEPTH : len;
      hm  = $urandom_range(3, 0);
      if (hm == 3 && ne < 2) hm = 0;
      hk  = (hm == 0) ? 0 : (hm == 3) ? $urandom_range(ne - 1, 1) : $urandom_range(ne, 1);
      run_prog(len, 1, 4, hm, hk, (r % 3 == 0) ? 3 : -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
